// File: rtl/transpad_req_arb_if.sv
// Requester bus plus transpad control-unit pins shared by the arbiter and its environment.
// master = requesters/translation unit side, slave = arbiter side.
interface transpad_req_arb_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CFG_W = 32
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*CFG_W-1:0] req_cfg;
  logic [NREQ-1:0]       req_stop;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  done_err;
  logic                  busy;
  logic [OW-1:0]         owner;
  logic                  tp_start_req;
  logic [CFG_W-1:0]      tp_cfg;
  logic                  tp_start_ok;
  logic                  tp_stop_req;
  logic                  tp_act;

  modport master (
    output req, req_cfg, req_stop, tp_start_ok, tp_act,
    input  gnt, done, done_err, busy, owner, tp_start_req, tp_cfg, tp_stop_req
  );

  modport slave (
    input  req, req_cfg, req_stop, tp_start_ok, tp_act,
    output gnt, done, done_err, busy, owner, tp_start_req, tp_cfg, tp_stop_req
  );
endinterface

// File: rtl/transpad_req_arb.sv
// Round-robin arbiter sharing one transpad translation unit between NREQ requesters;
// sequences start/stop handshake, detects completion from tp_act, returns done/err.
module transpad_req_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CFG_W = 32,
  parameter int unsigned TMO_W = 16
) (
  input logic                clk,
  input logic                rst,
  transpad_req_arb_if.slave  bus
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CFG_W-1:0] tp_cfg_q, tp_cfg_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             done_err_q, done_err_d;
  logic             busy_q, busy_d;
  logic             tp_start_req_q, tp_start_req_d;
  logic             tp_stop_req_q, tp_stop_req_d;
  logic             act_seen_q, act_seen_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [OW-1:0]    winner;
  logic [OW-1:0]    idx;
  logic             found;
  logic [TMO_W-1:0] tmo_nxt;
  logic             err;

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = OW'((32'(rr_ptr_q) + i) % NREQ);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    tp_cfg_d   = tp_cfg_q;
    gnt_d      = gnt_q;
    act_seen_d = act_seen_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_nxt    = TMO_W'(tmo_cnt_q + 1'b1);
    err        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d        = winner;
          tp_cfg_d       = bus.req_cfg[32'(winner) * CFG_W +: CFG_W];
          gnt_d          = '0;
          gnt_d[winner]  = 1'b1;
          tmo_cnt_d      = '0;
          act_seen_d     = 1'b0;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Abort before start wins over acceptance; unit never started.
        if (bus.req_stop[owner_q]) begin
          state_d = S_DONE;
          err     = 1'b1;
        end else if (bus.tp_start_ok) begin
          state_d = S_RUN;
        end else begin
          tmo_cnt_d = tmo_nxt;
          if (tmo_nxt == '1) begin
            state_d = S_DONE;
            err     = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (bus.tp_act) act_seen_d = 1'b1;
        // Abort takes priority over a completion seen in the same cycle.
        if (bus.req_stop[owner_q]) begin
          state_d = S_STOP;
        end else if (act_seen_q && !bus.tp_act) begin
          state_d = S_DONE;
        end
      end
      S_STOP: begin
        if (!bus.tp_act) begin
          state_d = S_DONE;
          err     = 1'b1;
        end
      end
      S_DONE: begin
        gnt_d    = '0;
        rr_ptr_d = (owner_q == OW'(NREQ - 1)) ? '0 : OW'(owner_q + 1'b1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Moore outputs derived from the next state so they are registered.
    done_d          = '0;
    if (state_d == S_DONE) done_d[owner_d] = 1'b1;
    done_err_d      = (state_d == S_DONE) && err;
    busy_d          = (state_d != S_IDLE);
    tp_start_req_d  = (state_d == S_ISSUE);
    tp_stop_req_d   = (state_d == S_STOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      tp_cfg_q       <= '0;
      gnt_q          <= '0;
      done_q         <= '0;
      done_err_q     <= 1'b0;
      busy_q         <= 1'b0;
      tp_start_req_q <= 1'b0;
      tp_stop_req_q  <= 1'b0;
      act_seen_q     <= 1'b0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      tp_cfg_q       <= tp_cfg_d;
      gnt_q          <= gnt_d;
      done_q         <= done_d;
      done_err_q     <= done_err_d;
      busy_q         <= busy_d;
      tp_start_req_q <= tp_start_req_d;
      tp_stop_req_q  <= tp_stop_req_d;
      act_seen_q     <= act_seen_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.done_err     = done_err_q;
  assign bus.busy         = busy_q;
  assign bus.owner        = owner_q;
  assign bus.tp_start_req = tp_start_req_q;
  assign bus.tp_cfg       = tp_cfg_q;
  assign bus.tp_stop_req  = tp_stop_req_q;
endmodule
